// File: rtl/eeprom_page_scheduler.sv
// eeprom_page_scheduler: ping-pong page buffering of ADC bytes and I2C page-write
// sequencing for a 24LC256 through a byte-level I2C engine.
// Optional feature macro: ACK_POLL_EN (acknowledge polling replaces the fixed
// write-cycle wait; default build uses the fixed TWC_CYCLES wait).
module eeprom_page_scheduler #(
  parameter int         PAGE_BYTES = 64,
  parameter int         ADDR_W     = 15,
  parameter logic [2:0] DEV_ADDR   = 3'b000,
  parameter int         TWC_CYCLES = 250000,
  parameter int         MAX_RETRY  = 3
) (
  input  logic              CLK_50MHz,
  input  logic              RESET,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [7:0]        sample_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_start,
  output logic              cmd_stop,
  output logic [7:0]        cmd_byte,
  input  logic              rsp_valid,
  input  logic              rsp_nack,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              page_done,
  output logic              overflow,
  output logic              error,
  output logic              mem_full
);

  localparam int IDX_W = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
  localparam int ATT_W = $clog2(MAX_RETRY + 2);
`ifdef ACK_POLL_EN
  localparam int TMR_W = $clog2(2 * TWC_CYCLES + 1);
  localparam logic [TMR_W-1:0] POLL_LAST = TMR_W'(2 * TWC_CYCLES - 1);
`else
  localparam int TMR_W = $clog2(TWC_CYCLES + 1);
`endif
  localparam logic [TMR_W-1:0] TWC_LAST  = TMR_W'(TWC_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAGE_BYTES - 1);
  localparam logic [ATT_W-1:0] ATT_MAX   = ATT_W'(MAX_RETRY);
  localparam logic [7:0]       CTRL_BYTE = {4'b1010, DEV_ADDR, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE, S_CTRL, S_ADDR_HI, S_ADDR_LO, S_DATA, S_ABORT, S_TWC, S_RETRY
  } state_e;

  state_e            state_q, state_d;
  logic              outst_q, outst_d;
  logic              sel_q, sel_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [ATT_W-1:0]  att_q, att_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              page_done_q, page_done_d;
  logic              error_q, error_d;
  logic              mem_full_q, mem_full_d;
  logic              overflow_q, overflow_d;
  logic [1:0]        full_q, full_d;
  logic              fill_q, fill_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;

  logic [7:0]  bank_q [2][PAGE_BYTES];
  logic        bank_we, bank_wsel;
  logic [1:0]  rel;
  logic        send, got_rsp, to_retry, advance;
  logic [15:0] addr16;

  assign addr16 = 16'(addr_q);

  // FSM next-state, command outputs and page bookkeeping
  always_comb begin
    state_d     = state_q;
    outst_d     = outst_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    att_d       = att_q;
    addr_d      = addr_q;
    page_done_d = 1'b0;
    error_d     = error_q;
    mem_full_d  = mem_full_q;
    rel         = 2'b00;
    send        = 1'b0;
    to_retry    = 1'b0;
    advance     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_start   = 1'b0;
    cmd_stop    = 1'b0;
    cmd_byte    = 8'h00;
    // responses only count while a command is actually outstanding
    got_rsp     = outst_q && rsp_valid;
    case (state_q)
      S_IDLE: begin
        if (!mem_full_q && (full_q != 2'b00)) begin
          sel_d   = ~full_q[0];
          att_d   = '0;
          state_d = S_CTRL;
        end
      end
      S_CTRL: begin
        send      = 1'b1;
        cmd_byte  = CTRL_BYTE;
        cmd_start = 1'b1;
        if (got_rsp) begin
          if (rsp_nack) to_retry = 1'b1;
          else          state_d  = S_ADDR_HI;
        end
      end
      S_ADDR_HI: begin
        send     = 1'b1;
        cmd_byte = addr16[15:8];
        if (got_rsp) state_d = rsp_nack ? S_ABORT : S_ADDR_LO;
      end
      S_ADDR_LO: begin
        send     = 1'b1;
        cmd_byte = addr16[7:0];
        if (got_rsp) begin
          state_d = rsp_nack ? S_ABORT : S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        send     = 1'b1;
        cmd_byte = bank_q[sel_q][idx_q];
        cmd_stop = (idx_q == LAST_IDX);
        if (got_rsp) begin
          if (rsp_nack) state_d = S_ABORT;
          else if (idx_q == LAST_IDX) begin
            state_d = S_TWC;
            tmr_d   = '0;
          end else idx_d = idx_q + IDX_W'(1);
        end
      end
      S_ABORT: begin
        // dummy byte just to get a STOP onto the bus; its ACK is irrelevant
        send     = 1'b1;
        cmd_byte = 8'hFF;
        cmd_stop = 1'b1;
        if (got_rsp) to_retry = 1'b1;
      end
`ifdef ACK_POLL_EN
      S_TWC: begin
        send      = 1'b1;
        cmd_byte  = CTRL_BYTE;
        cmd_start = 1'b1;
        cmd_stop  = 1'b1;
        if (tmr_q != POLL_LAST) tmr_d = tmr_q + TMR_W'(1);
        if (got_rsp) begin
          if (!rsp_nack) begin
            page_done_d = 1'b1;
            advance     = 1'b1;
          end else if (tmr_q == POLL_LAST) begin
            error_d     = 1'b1;
            page_done_d = 1'b1;
            advance     = 1'b1;
          end
        end
      end
`else
      S_TWC: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == TWC_LAST) begin
          page_done_d = 1'b1;
          advance     = 1'b1;
        end
      end
`endif
      S_RETRY: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == TWC_LAST) begin
          if (att_q <= ATT_MAX) state_d = S_CTRL;
          else begin
            error_d = 1'b1;
            advance = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (to_retry) begin
      state_d = S_RETRY;
      tmr_d   = '0;
      att_d   = att_q + ATT_W'(1);
    end
    if (advance) begin
      rel[sel_q] = 1'b1;
      addr_d     = addr_q + ADDR_W'(PAGE_BYTES);
      if (addr_d == '0) mem_full_d = 1'b1;
      state_d    = S_IDLE;
    end
    cmd_valid = send && !outst_q;
    if (cmd_valid && cmd_ready) outst_d = 1'b1;
    if (got_rsp)                outst_d = 1'b0;
  end

  // Fill side: bank release is applied before the incoming sample is placed
  always_comb begin
    full_d     = full_q & ~rel;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    bank_we    = 1'b0;
    bank_wsel  = fill_q;
    if (full_d[fill_q] && !full_d[~fill_q]) fill_d = ~fill_q;
    if (sample_valid && enable && !mem_full_q) begin
      if (full_d[fill_d]) overflow_d = 1'b1;
      else begin
        bank_we   = 1'b1;
        bank_wsel = fill_d;
        if (cnt_q == LAST_IDX) begin
          full_d[fill_d] = 1'b1;
          cnt_d          = '0;
          if (!full_d[~fill_d]) fill_d = ~fill_d;
        end else cnt_d = cnt_q + IDX_W'(1);
      end
    end
  end

  // Control and status registers
  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      outst_q     <= 1'b0;
      sel_q       <= 1'b0;
      idx_q       <= '0;
      tmr_q       <= '0;
      att_q       <= '0;
      addr_q      <= '0;
      page_done_q <= 1'b0;
      error_q     <= 1'b0;
      mem_full_q  <= 1'b0;
      overflow_q  <= 1'b0;
      full_q      <= 2'b00;
      fill_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      outst_q     <= outst_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      att_q       <= att_d;
      addr_q      <= addr_d;
      page_done_q <= page_done_d;
      error_q     <= error_d;
      mem_full_q  <= mem_full_d;
      overflow_q  <= overflow_d;
      full_q      <= full_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
    end
  end

  // Page buffer storage; contents are meaningless until a bank is marked full
  always_ff @(posedge CLK_50MHz) begin
    if (bank_we) bank_q[bank_wsel][cnt_q] <= sample_data;
  end

  assign wr_addr   = addr_q;
  assign busy      = (state_q != S_IDLE);
  assign page_done = page_done_q;
  assign overflow  = overflow_q;
  assign error     = error_q;
  assign mem_full  = mem_full_q;

endmodule

// File: tb/tb_eeprom_page_scheduler.sv
// Bench for eeprom_page_scheduler: a behavioural I2C byte engine logs every
// accepted command; expected command streams are built from page-level rules.
module tb_eeprom_page_scheduler;
  localparam int PB  = 64;
  localparam int AW  = 7;
  localparam int TWC = 40;
  localparam int MR  = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic enable = 1'b0, sample_valid = 1'b0;
  logic [7:0] sample_data = 8'h00;
  logic cmd_valid, cmd_start, cmd_stop;
  logic cmd_ready = 1'b0, rsp_valid = 1'b0, rsp_nack = 1'b0;
  logic [7:0] cmd_byte;
  logic [AW-1:0] wr_addr;
  logic busy, page_done, overflow, error, mem_full;

  always #5 clk = ~clk;

  eeprom_page_scheduler #(.PAGE_BYTES(PB), .ADDR_W(AW), .DEV_ADDR(3'b000),
                          .TWC_CYCLES(TWC), .MAX_RETRY(MR)) dut (
    .CLK_50MHz(clk), .RESET(rst_n), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_byte(cmd_byte),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .wr_addr(wr_addr), .busy(busy),
    .page_done(page_done), .overflow(overflow), .error(error), .mem_full(mem_full));

  typedef struct packed { logic [7:0] b; logic s; logic p; } cmd_t;

  int checks = 0, failures = 0;
  cmd_t log_q[$];
  cmd_t exp_q[$];
  logic [7:0] sent_q[$];
  int ready_mode = 0, nack_idx = -1;
  bit nack_ctrl = 0;
  int cyc = 0, pd_cnt = 0, pd_cyc = 0, last_rsp_cyc = 0, proto_err = 0;
  bit pend = 0, hold_v = 0, pend_nack = 0;
  int pend_dly = 0;
  cmd_t hold_c;

  // Behavioural I2C byte engine plus handshake protocol monitor
  always @(negedge clk) begin
    cmd_t cur;
    cyc++;
    if (!rst_n) begin
      cmd_ready = 0; rsp_valid = 0; rsp_nack = 0; pend = 0; hold_v = 0;
      log_q.delete(); pd_cnt = 0; proto_err = 0;
    end else begin
      if (page_done) begin pd_cnt++; pd_cyc = cyc; end
      rsp_valid = 0; rsp_nack = 0;
      if (pend) begin
        pend_dly--;
        if (pend_dly == 0) begin
          rsp_valid = 1; rsp_nack = pend_nack; pend = 0; last_rsp_cyc = cyc;
        end
      end
      cur = '{b: cmd_byte, s: cmd_start, p: cmd_stop};
      if (cmd_valid && (pend || rsp_valid)) proto_err++;
      if (hold_v && (!cmd_valid || cur != hold_c)) proto_err++;
      case (ready_mode)
        0: cmd_ready = 1'b1;
        1: cmd_ready = (cyc % 10 == 0);
        2: cmd_ready = 1'b0;
        default: cmd_ready = 1'($urandom_range(0, 1));
      endcase
      if (cmd_valid && cmd_ready) begin
        pend_nack = (log_q.size() == nack_idx) || (nack_ctrl && cmd_start);
        log_q.push_back(cur);
        pend = 1; pend_dly = $urandom_range(1, 3); hold_v = 0;
      end else if (cmd_valid) begin
        hold_v = 1; hold_c = cur;
      end else hold_v = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: one page attempt as seen on the engine; nack_pos<0 = success,
  // otherwise bytes up to the NACKed one, plus the abort STOP if past control.
  function automatic void model_attempt(input int addr, input int base, input int nack_pos);
    cmd_t seq[$];
    seq.push_back(cmd_t'({8'hA0, 1'b1, 1'b0}));
    seq.push_back(cmd_t'({8'((addr >> 8) & 8'hFF), 1'b0, 1'b0}));
    seq.push_back(cmd_t'({8'(addr & 8'hFF), 1'b0, 1'b0}));
    for (int i = 0; i < PB; i++) seq.push_back(cmd_t'({sent_q[base + i], 1'b0, 1'(i == PB - 1)}));
    if (nack_pos < 0) foreach (seq[i]) exp_q.push_back(seq[i]);
    else begin
      for (int i = 0; i <= nack_pos; i++) exp_q.push_back(seq[i]);
      if (nack_pos > 0) exp_q.push_back(cmd_t'({8'hFF, 1'b0, 1'b1}));
    end
  endfunction

  task automatic apply_reset();
    @(negedge clk); #2;
    rst_n = 0; sample_valid = 0; enable = 0; sample_data = 0;
    sent_q.delete(); exp_q.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
  endtask

  task automatic send_samples(input int n, input bit en, input bit incr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_valid = 1; enable = en;
      sample_data = incr ? 8'(i) : 8'($urandom);
      if (en) sent_q.push_back(sample_data);
    end
    @(negedge clk);
    sample_valid = 0;
  endtask

  task automatic test_reset();
    ready_mode = 0; nack_idx = -1; nack_ctrl = 0;
    apply_reset();
    #3;
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid); end
    checks++; if ({cmd_start, cmd_stop, cmd_byte} !== 10'h0) begin failures++; $display("FAIL reset_cmd got=%h exp=0", {cmd_start, cmd_stop, cmd_byte}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wr_addr !== '0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
    checks++; if ({page_done, overflow, error, mem_full} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {page_done, overflow, error, mem_full}); end
  endtask

  task automatic test_single_page();
    int bad;
    ready_mode = 0; nack_idx = -1; nack_ctrl = 0;
    apply_reset();
    send_samples(PB, 1'b1, 1'b1);
    model_attempt(0, 0, -1);
    for (int i = 0; i < 3000 && pd_cnt < 1; i++) @(negedge clk);
    #3;
    checks++; if (pd_cnt != 1) begin failures++; $display("FAIL single_page_done got=%0d exp=1", pd_cnt); end
    checks++; if (pd_cyc - last_rsp_cyc != TWC + 1) begin failures++; $display("FAIL single_twc_delay got=%0d exp=%0d", pd_cyc - last_rsp_cyc, TWC + 1); end
    checks++; if (wr_addr !== AW'(PB)) begin failures++; $display("FAIL single_wr_addr got=%h exp=%h", wr_addr, AW'(PB)); end
    checks++; if (log_q.size() != exp_q.size()) begin failures++; $display("FAIL single_len got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && (i >= log_q.size() || log_q[i] !== exp_q[i])) bad = i;
    checks++; if (bad >= 0) begin failures++; $display("FAIL single_seq idx=%0d got=%h exp=%h", bad, (bad < log_q.size()) ? log_q[bad] : cmd_t'('x), exp_q[bad]); end
    repeat (2) @(negedge clk); #3;
    checks++; if ({busy, error, overflow} !== 3'b000) begin failures++; $display("FAIL single_idle got=%b exp=000", {busy, error, overflow}); end
    checks++; if (proto_err != 0) begin failures++; $display("FAIL single_protocol got=%0d exp=0", proto_err); end
  endtask

  task automatic test_ping_pong();
    int bad;
    ready_mode = 1; nack_idx = -1; nack_ctrl = 0;
    apply_reset();
    send_samples(2 * PB, 1'b1, 1'b0);
    model_attempt(0, 0, -1);
    model_attempt(PB, PB, -1);
    for (int i = 0; i < 6000 && pd_cnt < 1; i++) @(negedge clk);
    #3;
    checks++; if (wr_addr !== AW'(PB)) begin failures++; $display("FAIL pp_first_addr got=%h exp=%h", wr_addr, AW'(PB)); end
    for (int i = 0; i < 6000 && pd_cnt < 2; i++) @(negedge clk);
    repeat (2) @(negedge clk); #3;
    checks++; if (pd_cnt != 2) begin failures++; $display("FAIL pp_pages got=%0d exp=2", pd_cnt); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pp_overflow got=%b exp=0", overflow); end
    checks++; if ({mem_full, wr_addr} !== {1'b1, AW'(0)}) begin failures++; $display("FAIL pp_wrap got=%b/%h exp=1/0", mem_full, wr_addr); end
    checks++; if (log_q.size() != exp_q.size()) begin failures++; $display("FAIL pp_len got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && (i >= log_q.size() || log_q[i] !== exp_q[i])) bad = i;
    checks++; if (bad >= 0) begin failures++; $display("FAIL pp_seq idx=%0d got=%h exp=%h", bad, (bad < log_q.size()) ? log_q[bad] : cmd_t'('x), exp_q[bad]); end
    checks++; if (proto_err != 0) begin failures++; $display("FAIL pp_protocol got=%0d exp=0", proto_err); end
  endtask

  // Continues from the wrapped state left by test_ping_pong
  task automatic test_wrap();
    int n0;
    n0 = log_q.size();
    ready_mode = 3;
    send_samples(PB + 6, 1'b1, 1'b0);
    repeat (TWC + 20) @(negedge clk); #3;
    checks++; if (log_q.size() != n0) begin failures++; $display("FAIL wrap_no_cmds got=%0d exp=%0d", log_q.size(), n0); end
    checks++; if ({busy, overflow, mem_full} !== 3'b001) begin failures++; $display("FAIL wrap_state got=%b exp=001", {busy, overflow, mem_full}); end
    checks++; if (wr_addr !== '0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", wr_addr); end
  endtask

  task automatic test_overflow();
    int bad;
    ready_mode = 2; nack_idx = -1; nack_ctrl = 0;
    apply_reset();
    send_samples(2 * PB + 1, 1'b1, 1'b0);
    repeat (3) @(negedge clk); #3;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (log_q.size() != 0) begin failures++; $display("FAIL ovf_no_accept got=%0d exp=0", log_q.size()); end
    checks++; if ({busy, cmd_valid, cmd_start, cmd_byte} !== {3'b111, 8'hA0}) begin failures++; $display("FAIL ovf_offer got=%h exp=%h", {busy, cmd_valid, cmd_start, cmd_byte}, {3'b111, 8'hA0}); end
    model_attempt(0, 0, -1);
    model_attempt(PB, PB, -1);
    ready_mode = 0;
    for (int i = 0; i < 4000 && pd_cnt < 2; i++) @(negedge clk);
    #3;
    checks++; if (pd_cnt != 2) begin failures++; $display("FAIL ovf_pages got=%0d exp=2", pd_cnt); end
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && (i >= log_q.size() || log_q[i] !== exp_q[i])) bad = i;
    checks++; if (bad >= 0 || log_q.size() != exp_q.size()) begin failures++; $display("FAIL ovf_seq idx=%0d len=%0d exp_len=%0d", bad, log_q.size(), exp_q.size()); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_nack_retry();
    int bad;
    ready_mode = 3; nack_idx = 2; nack_ctrl = 0;
    apply_reset();
    send_samples(5, 1'b0, 1'b0);
    send_samples(PB, 1'b1, 1'b0);
    model_attempt(0, 0, 2);
    model_attempt(0, 0, -1);
    for (int i = 0; i < 4000 && pd_cnt < 1; i++) @(negedge clk);
    repeat (3) @(negedge clk); #3;
    checks++; if (pd_cnt != 1) begin failures++; $display("FAIL nack_pages got=%0d exp=1", pd_cnt); end
    checks++; if ({error, busy} !== 2'b00) begin failures++; $display("FAIL nack_state got=%b exp=00", {error, busy}); end
    checks++; if (wr_addr !== AW'(PB)) begin failures++; $display("FAIL nack_addr got=%h exp=%h", wr_addr, AW'(PB)); end
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && (i >= log_q.size() || log_q[i] !== exp_q[i])) bad = i;
    checks++; if (bad >= 0 || log_q.size() != exp_q.size()) begin failures++; $display("FAIL nack_seq idx=%0d len=%0d exp_len=%0d", bad, log_q.size(), exp_q.size()); end
    checks++; if (proto_err != 0) begin failures++; $display("FAIL nack_protocol got=%0d exp=0", proto_err); end
  endtask

  task automatic test_retry_exhaustion();
    int bad;
    ready_mode = 0; nack_idx = -1; nack_ctrl = 1;
    apply_reset();
    send_samples(PB, 1'b1, 1'b0);
    for (int a = 0; a <= MR; a++) model_attempt(0, 0, 0);
    for (int i = 0; i < 4000 && error !== 1'b1; i++) @(negedge clk);
    repeat (3) @(negedge clk); #3;
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL exh_error got=%b exp=1", error); end
    checks++; if (wr_addr !== AW'(PB)) begin failures++; $display("FAIL exh_addr got=%h exp=%h", wr_addr, AW'(PB)); end
    checks++; if ({busy, pd_cnt != 0} !== 2'b00) begin failures++; $display("FAIL exh_idle busy=%b pages=%0d exp=0/0", busy, pd_cnt); end
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && (i >= log_q.size() || log_q[i] !== exp_q[i])) bad = i;
    checks++; if (bad >= 0 || log_q.size() != exp_q.size()) begin failures++; $display("FAIL exh_seq idx=%0d len=%0d exp_len=%0d", bad, log_q.size(), exp_q.size()); end
    nack_ctrl = 0;
  endtask

  task automatic test_reset_midway();
    ready_mode = 3; nack_idx = -1; nack_ctrl = 0;
    apply_reset();
    send_samples(PB, 1'b1, 1'b0);
    for (int i = 0; i < 3000 && !(log_q.size() >= 5 && cmd_valid === 1'b1); i++) @(negedge clk);
    checks++; if (cmd_valid !== 1'b1) begin failures++; $display("FAIL mid_offer got=%b exp=1", cmd_valid); end
    #2 rst_n = 0;
    #1;
    checks++; if ({cmd_valid, busy} !== 2'b00) begin failures++; $display("FAIL mid_async_drop got=%b exp=00", {cmd_valid, busy}); end
    checks++; if (wr_addr !== '0) begin failures++; $display("FAIL mid_addr got=%h exp=0", wr_addr); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_single_page();
    test_ping_pong();
    test_wrap();
    test_overflow();
    test_nack_retry();
    test_retry_exhaustion();
    test_reset_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
